apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator: accepts single read/write requests on a valid/ready request port and drives APB3 PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Returns PRDATA/PSLVERR on a valid/ready response port.
- Aborts transfers that exceed a programmable PREADY wait limit.
- Sits between an internal command source (self-test engine, CPU shim) and the sdram_controller APB slave port.

Parameters:
- ADDR_W, 16, APB address width
- DATA_W, 16, APB data width
- TIMEOUT_CYCLES, 256, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  in  1  APB clock, all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR seen or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- busy  out  1  state != IDLE
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Clocking and reset: one clock PCLK; PRESETn asynchronous assert, synchronous deassert at the system level.
- Reset values: all outputs 0 except req_ready=1; state=IDLE; wait counter 0.
- FSM states and transitions:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - Edge with PREADY=1: capture PRDATA into rsp_rdata (reads only; writes load 0), rsp_err=PSLVERR, rsp_timeout=0. Go to RESP.
    - Edge with PREADY=0: increment the wait counter.
    - Abort: if TIMEOUT_CYCLES!=0, PREADY=0 and counter==TIMEOUT_CYCLES-1, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1, response fields stable. On an edge with rsp_ready=1, go to IDLE and clear the counter.
- Timing: minimum latency is request accept edge, then SETUP, ACCESS, RESP; rsp_valid rises 3 edges after acceptance when PREADY is already 1.
- Simultaneous events:
  - PREADY=1 on the timeout edge: PREADY wins (normal completion).
  - Back-to-back requests: req_ready is only high in IDLE, so at most one transfer is outstanding and the minimum turnaround is 1 IDLE cycle.
- APB rules:
  - PADDR/PWRITE/PWDATA hold from SETUP through ACCESS, and hold their last value while idle.
  - PENABLE is never 1 while PSEL=0.
  - PSEL drops in the cycle after PREADY, or immediately after an abort.
- Request/response rules:
  - req_* inputs are ignored outside IDLE.
  - rsp_* outputs are undefined-but-stable while rsp_valid=0 (implement as hold).
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, no response is emitted, and any pending response is discarded.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit; it saturates and never wraps.

Decomposition:
- Shared package apb_pkg:
  - ADDR_W/DATA_W defaults
  - apb_state_e enum {IDLE, SETUP, ACCESS, RESP}
  - apb_req_t struct {write, addr, wdata}
  - apb_rsp_t struct {rdata, err, timeout}
- No sub-module is needed; the wait counter stays inline.

Test Plan:
- Write: req addr=16'h0010, wdata=16'hA5A5, PREADY=1 -> PSEL in cycle 1, PENABLE in cycle 2, rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: req addr=16'h0020, PREADY low 3 ACCESS cycles, then PRDATA=16'h1234 -> rsp_rdata=16'h1234, PADDR stable throughout.
- PSLVERR: read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY held 0 -> ACCESS lasts 4 cycles, then PSEL=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with PREADY=1 on the 4th cycle -> normal completion.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data held, req_ready=0, a new req_valid is ignored. After rsp_ready pulses, the next request is accepted from IDLE.
- Reset mid-ACCESS: PRESETn low during ACCESS -> PSEL/PENABLE/rsp_valid go 0 asynchronously, req_ready=1 after release, no stale response.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB initiator bridge.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 16;
    localparam int unsigned APB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 initiator: single outstanding request in, APB transfer out, response back,
// with an optional PREADY wait-state limit that aborts stalled transfers.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pwrite_d    = req_write;
                    paddr_d     = req_addr;
                    pwdata_d    = req_wdata;
                    psel_d      = 1'b1;
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over an abort on the same edge.
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a 4-cycle PREADY limit.
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int n_chk  = 0;
    int n_fail = 0;

    apb_master_bridge #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        chk_b("rst_req_ready", req_ready, 1'b1);
        chk_b("rst_psel", PSEL, 1'b0);
        chk_b("rst_penable", PENABLE, 1'b0);
        chk_b("rst_rsp_valid", rsp_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_w("rst_paddr", PADDR, 16'h0000);
        PRESETn = 1'b1;
        tick();

        // Zero-wait write
        issue(1'b1, 16'h0010, 16'hA5A5);
        PREADY = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_b("wr_c1_psel", PSEL, 1'b1);
        chk_b("wr_c1_penable", PENABLE, 1'b0);
        chk_b("wr_c1_pwrite", PWRITE, 1'b1);
        chk_w("wr_c1_paddr", PADDR, 16'h0010);
        chk_w("wr_c1_pwdata", PWDATA, 16'hA5A5);
        chk_b("wr_c1_req_ready", req_ready, 1'b0);
        tick();
        chk_b("wr_c2_psel", PSEL, 1'b1);
        chk_b("wr_c2_penable", PENABLE, 1'b1);
        chk_b("wr_c2_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk_b("wr_c3_rsp_valid", rsp_valid, 1'b1);
        chk_b("wr_c3_psel", PSEL, 1'b0);
        chk_b("wr_c3_penable", PENABLE, 1'b0);
        chk_b("wr_c3_err", rsp_err, 1'b0);
        chk_w("wr_c3_rdata", rsp_rdata, 16'h0000);
        chk_b("wr_c3_busy", busy, 1'b1);
        release_rsp();
        chk_b("wr_idle_rsp_valid", rsp_valid, 1'b0);
        chk_b("wr_idle_req_ready", req_ready, 1'b1);
        chk_w("wr_idle_paddr_hold", PADDR, 16'h0010);

        // Read with 3 wait states, completing on the 4th ACCESS cycle
        issue(1'b0, 16'h0020, 16'h0000);
        PREADY = 1'b0;
        PRDATA = 16'hDEAD;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b("rd_wait_penable", PENABLE, 1'b1);
            chk_w("rd_wait_paddr", PADDR, 16'h0020);
            chk_b("rd_wait_rsp_valid", rsp_valid, 1'b0);
        end
        tick();
        PREADY = 1'b1;
        PRDATA = 16'h1234;
        chk_b("rd_4th_psel", PSEL, 1'b1);
        tick();
        chk_b("rd_rsp_valid", rsp_valid, 1'b1);
        chk_w("rd_rdata", rsp_rdata, 16'h1234);
        chk_b("rd_err", rsp_err, 1'b0);
        chk_b("rd_timeout", rsp_timeout, 1'b0);
        release_rsp();

        // Slave error, then response backpressure with an ignored request
        issue(1'b0, 16'h0030, 16'h0000);
        PRDATA = 16'hBEEF;
        PSLVERR = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        chk_b("slverr_err", rsp_err, 1'b1);
        chk_b("slverr_timeout", rsp_timeout, 1'b0);
        chk_w("slverr_rdata", rsp_rdata, 16'hBEEF);
        issue(1'b1, 16'h0040, 16'h7777);
        PSLVERR = 1'b0;
        PRDATA = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_b("bp_rsp_valid", rsp_valid, 1'b1);
            chk_w("bp_rdata", rsp_rdata, 16'hBEEF);
            chk_b("bp_err", rsp_err, 1'b1);
            chk_b("bp_req_ready", req_ready, 1'b0);
            chk_b("bp_psel", PSEL, 1'b0);
            chk_w("bp_paddr", PADDR, 16'h0030);
        end
        release_rsp();
        chk_b("bp_idle_req_ready", req_ready, 1'b1);
        chk_b("bp_idle_psel", PSEL, 1'b0);
        chk_b("bp_idle_rsp_valid", rsp_valid, 1'b0);
        tick();
        req_valid = 1'b0;
        chk_b("next_psel", PSEL, 1'b1);
        chk_w("next_paddr", PADDR, 16'h0040);
        chk_w("next_pwdata", PWDATA, 16'h7777);
        tick(); tick();
        chk_b("next_rsp_valid", rsp_valid, 1'b1);
        chk_b("next_err", rsp_err, 1'b0);
        chk_w("next_rdata", rsp_rdata, 16'h0000);
        release_rsp();

        // Timeout: PREADY never rises
        issue(1'b0, 16'h0050, 16'h0000);
        PREADY = 1'b0;
        PRDATA = 16'hFFFF;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_b("to_access_psel", PSEL, 1'b1);
            chk_b("to_access_penable", PENABLE, 1'b1);
        end
        tick();
        chk_b("to_psel", PSEL, 1'b0);
        chk_b("to_penable", PENABLE, 1'b0);
        chk_b("to_rsp_valid", rsp_valid, 1'b1);
        chk_b("to_err", rsp_err, 1'b1);
        chk_b("to_timeout", rsp_timeout, 1'b1);
        chk_w("to_rdata", rsp_rdata, 16'h0000);
        release_rsp();

        // PREADY on the would-be timeout edge completes normally
        issue(1'b0, 16'h0060, 16'h0000);
        PRDATA = 16'h5A5A;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        PREADY = 1'b1;
        tick();
        chk_b("edge_rsp_valid", rsp_valid, 1'b1);
        chk_b("edge_timeout", rsp_timeout, 1'b0);
        chk_b("edge_err", rsp_err, 1'b0);
        chk_w("edge_rdata", rsp_rdata, 16'h5A5A);
        release_rsp();

        // Reset during ACCESS
        issue(1'b0, 16'h0070, 16'h0000);
        PREADY = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk_b("mid_penable", PENABLE, 1'b1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_b("arst_psel", PSEL, 1'b0);
        chk_b("arst_penable", PENABLE, 1'b0);
        chk_b("arst_rsp_valid", rsp_valid, 1'b0);
        chk_b("arst_busy", busy, 1'b0);
        tick();
        PRESETn = 1'b1;
        PREADY = 1'b1;
        chk_b("arst_req_ready", req_ready, 1'b1);
        tick(); tick(); tick();
        chk_b("arst_no_stale_rsp", rsp_valid, 1'b0);
        chk_b("arst_no_stale_psel", PSEL, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
